// File: rtl/control_unit.sv
// Instruction control unit: combinational opcode decode plus a RUN/MEM_WAIT/HALT/FAULT
// sequencer that gates PC and write enables around data-memory waits.
module control_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  OpCode,
  input  logic        zero,
  input  logic        mem_ready,
  output logic [1:0]  PCSrc,
  output logic [1:0]  RegDst,
  output logic        ExtSel,
  output logic        RegWrite,
  output logic        OpenSel,
  output logic        BSrc,
  output logic        MemWrite,
  output logic [1:0]  WBSrc,
  output logic        pc_en,
  output logic        mem_req,
  output logic        halted,
  output logic        fault,
  output logic        illegal,
  output logic [31:0] retired,
  output logic [15:0] stall_cycles
);

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_MEM_WAIT = 2'd1,
    S_HALT     = 2'd2,
    S_FAULT    = 2'd3
  } state_e;

  typedef struct packed {
    logic [1:0] pc_src;
    logic [1:0] reg_dst;
    logic       ext_sel;
    logic       reg_write;
    logic       b_src;
    logic       mem_write;
    logic [1:0] wb_src;
    logic       is_mem;
    logic       is_halt;
    logic       is_illegal;
  } dec_t;

  state_e      state_q, state_d;
  logic [3:0]  wait_q, wait_d;
  logic [31:0] retired_q, retired_d;
  logic [15:0] stall_q, stall_d;
  dec_t        dec;

  // NOTE: every field gets a default before the case so no latch is inferred.
  always_comb begin
    dec = '0;
    unique case (OpCode)
      6'h00: begin dec.reg_dst = 2'b01; dec.reg_write = 1'b1; dec.wb_src = 2'b01; end
      6'h08: begin
        dec.ext_sel = 1'b1; dec.b_src = 1'b1; dec.reg_write = 1'b1; dec.wb_src = 2'b01;
      end
      6'h0C, 6'h0D: begin dec.b_src = 1'b1; dec.reg_write = 1'b1; dec.wb_src = 2'b01; end
      6'h23: begin
        dec.ext_sel = 1'b1; dec.b_src = 1'b1; dec.reg_write = 1'b1; dec.is_mem = 1'b1;
      end
      6'h2B: begin
        dec.ext_sel = 1'b1; dec.b_src = 1'b1; dec.mem_write = 1'b1; dec.is_mem = 1'b1;
      end
      6'h04: begin dec.ext_sel = 1'b1; dec.pc_src = zero ? 2'b01 : 2'b00; end
      6'h05: begin dec.ext_sel = 1'b1; dec.pc_src = zero ? 2'b00 : 2'b01; end
      6'h02: dec.pc_src = 2'b11;
      6'h03: begin
        dec.pc_src = 2'b11; dec.reg_dst = 2'b10; dec.reg_write = 1'b1; dec.wb_src = 2'b10;
      end
      6'h06: dec.pc_src = 2'b10;
      6'h3F: dec.is_halt = 1'b1;
      default: dec.is_illegal = 1'b1;
    endcase
  end

  // NOTE: combinational logic uses blocking '=' so later lines see earlier overrides.
  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    retired_d = retired_q;
    stall_d   = stall_q;
    PCSrc     = 2'b00;
    RegDst    = 2'b00;
    ExtSel    = 1'b0;
    RegWrite  = 1'b0;
    BSrc      = 1'b0;
    MemWrite  = 1'b0;
    WBSrc     = 2'b00;
    pc_en     = 1'b0;
    mem_req   = 1'b0;
    illegal   = 1'b0;

    unique case (state_q)
      S_RUN: begin
        if (dec.is_halt) begin
          retired_d = retired_q + 32'd1;
          state_d   = S_HALT;
        end else begin
          PCSrc    = dec.pc_src;
          RegDst   = dec.reg_dst;
          ExtSel   = dec.ext_sel;
          BSrc     = dec.b_src;
          WBSrc    = dec.wb_src;
          mem_req  = dec.is_mem;
          if (dec.is_mem && !mem_ready) begin
            wait_d  = 4'd0;
            state_d = S_MEM_WAIT;
          end else begin
            RegWrite  = dec.reg_write;
            MemWrite  = dec.mem_write;
            pc_en     = 1'b1;
            illegal   = dec.is_illegal;
            retired_d = retired_q + 32'd1;
          end
        end
      end
      S_MEM_WAIT: begin
        PCSrc   = dec.pc_src;
        RegDst  = dec.reg_dst;
        ExtSel  = dec.ext_sel;
        BSrc    = dec.b_src;
        WBSrc   = dec.wb_src;
        mem_req = 1'b1;
        if (mem_ready) begin
          RegWrite  = dec.reg_write;
          MemWrite  = dec.mem_write;
          pc_en     = 1'b1;
          retired_d = retired_q + 32'd1;
          state_d   = S_RUN;
        end else begin
          stall_d = (stall_q == 16'hFFFF) ? stall_q : stall_q + 16'd1;
          // The 16th consecutive unanswered wait cycle gives up on the memory.
          if (wait_q == 4'd15) state_d = S_FAULT;
          else                 wait_d  = wait_q + 4'd1;
        end
      end
      default: ;  // HALT and FAULT are sticky until reset.
    endcase

    if (rst) begin
      PCSrc    = 2'b00;
      RegDst   = 2'b00;
      ExtSel   = 1'b0;
      RegWrite = 1'b0;
      BSrc     = 1'b0;
      MemWrite = 1'b0;
      WBSrc    = 2'b00;
      pc_en    = 1'b0;
      mem_req  = 1'b0;
      illegal  = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking '<=' so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_RUN;
      wait_q    <= 4'd0;
      retired_q <= 32'd0;
      stall_q   <= 16'd0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      retired_q <= retired_d;
      stall_q   <= stall_d;
    end
  end

  assign OpenSel      = 1'b0;
  assign halted       = !rst && ((state_q == S_HALT) || (state_q == S_FAULT));
  assign fault        = !rst && (state_q == S_FAULT);
  assign retired      = retired_q;
  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_control_unit.sv
// Directed self-checking bench for control_unit: decode, memory waits, fault,
// halt and synchronous reset.
module tb_control_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  OpCode;
  logic        zero;
  logic        mem_ready;
  logic [1:0]  PCSrc;
  logic [1:0]  RegDst;
  logic        ExtSel;
  logic        RegWrite;
  logic        OpenSel;
  logic        BSrc;
  logic        MemWrite;
  logic [1:0]  WBSrc;
  logic        pc_en;
  logic        mem_req;
  logic        halted;
  logic        fault;
  logic        illegal;
  logic [31:0] retired;
  logic [15:0] stall_cycles;

  int total = 0;
  int bad   = 0;
  int exp_ret;

  control_unit dut (
    .clk(clk), .rst(rst), .OpCode(OpCode), .zero(zero), .mem_ready(mem_ready),
    .PCSrc(PCSrc), .RegDst(RegDst), .ExtSel(ExtSel), .RegWrite(RegWrite),
    .OpenSel(OpenSel), .BSrc(BSrc), .MemWrite(MemWrite), .WBSrc(WBSrc),
    .pc_en(pc_en), .mem_req(mem_req), .halted(halted), .fault(fault),
    .illegal(illegal), .retired(retired), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled mid-cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; OpCode = 6'h00; zero = 1'b0; mem_ready = 1'b0;
    #1;
    check("rst_pc_en", pc_en, 0);
    check("rst_regwrite", RegWrite, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_halted", halted, 0);
    check("rst_illegal", illegal, 0);
    tick(); tick();
    check("rst_retired", retired, 0);
    check("rst_stall", stall_cycles, 0);
    check("opensel", OpenSel, 0);
    rst = 1'b0;
    exp_ret = 0;

    // ADDI then BEQ taken, BNE not taken, R-ALU
    OpCode = 6'h08; #1;
    check("addi_regwrite", RegWrite, 1);
    check("addi_bsrc", BSrc, 1);
    check("addi_extsel", ExtSel, 1);
    check("addi_wbsrc", WBSrc, 2'b01);
    check("addi_pc_en", pc_en, 1);
    tick(); exp_ret++;
    OpCode = 6'h04; zero = 1'b1; #1;
    check("beq_pcsrc", PCSrc, 2'b01);
    check("beq_regwrite", RegWrite, 0);
    tick(); exp_ret++;
    check("retired_after_beq", retired, 2);
    OpCode = 6'h05; #1;
    check("bne_pcsrc", PCSrc, 2'b00);
    tick(); exp_ret++;
    OpCode = 6'h0C; #1;
    check("andi_extsel", ExtSel, 0);
    check("andi_regwrite", RegWrite, 1);
    tick(); exp_ret++;
    OpCode = 6'h00; zero = 1'b0; #1;
    check("ralu_regdst", RegDst, 2'b01);
    tick(); exp_ret++;

    // LW: issue cycle plus three unanswered wait cycles, then ready
    OpCode = 6'h23; mem_ready = 1'b0; #1;
    check("lw_issue_pc_en", pc_en, 0);
    check("lw_issue_mem_req", mem_req, 1);
    check("lw_issue_regwrite", RegWrite, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      check("lw_wait_pc_en", pc_en, 0);
      check("lw_wait_regwrite", RegWrite, 0);
      check("lw_wait_mem_req", mem_req, 1);
      tick();
    end
    check("lw_stall", stall_cycles, 3);
    check("lw_retired_pending", retired, exp_ret);
    mem_ready = 1'b1; #1;
    check("lw_done_pc_en", pc_en, 1);
    check("lw_done_regwrite", RegWrite, 1);
    check("lw_done_wbsrc", WBSrc, 2'b00);
    tick(); exp_ret++;
    check("lw_retired", retired, exp_ret);

    // Undefined opcode
    OpCode = 6'h3A; #1;
    check("ill_pulse", illegal, 1);
    check("ill_regwrite", RegWrite, 0);
    check("ill_memwrite", MemWrite, 0);
    check("ill_pcsrc", PCSrc, 2'b00);
    check("ill_pc_en", pc_en, 1);
    tick(); exp_ret++;
    OpCode = 6'h02; #1;
    check("ill_cleared", illegal, 0);
    check("j_pcsrc", PCSrc, 2'b11);
    check("ill_retired", retired, exp_ret);
    tick(); exp_ret++;

    // JAL and JR
    OpCode = 6'h03; #1;
    check("jal_pcsrc", PCSrc, 2'b11);
    check("jal_regdst", RegDst, 2'b10);
    check("jal_wbsrc", WBSrc, 2'b10);
    check("jal_regwrite", RegWrite, 1);
    tick(); exp_ret++;
    OpCode = 6'h06; #1;
    check("jr_pcsrc", PCSrc, 2'b10);
    tick(); exp_ret++;
    check("jumps_retired", retired, exp_ret);

    // Reset in the middle of a memory wait
    OpCode = 6'h23; mem_ready = 1'b0;
    tick(); tick();
    check("pre_rst_stall", stall_cycles, 4);
    rst = 1'b1; #1;
    check("rst_wait_mem_req", mem_req, 0);
    check("rst_wait_pc_en", pc_en, 0);
    tick();
    rst = 1'b0; OpCode = 6'h08; #1;
    check("post_rst_retired", retired, 0);
    check("post_rst_stall", stall_cycles, 0);
    check("post_rst_run", pc_en, 1);
    tick();

    // SW never acknowledged: fault after 16 wait cycles
    OpCode = 6'h2B; #1;
    check("sw_issue_memwrite", MemWrite, 0);
    tick();
    for (int i = 0; i < 16; i++) begin
      check("sw_wait_memwrite", MemWrite, 0);
      check("sw_wait_halted", halted, 0);
      tick();
    end
    check("sw_fault", fault, 1);
    check("sw_halted", halted, 1);
    check("sw_fault_mem_req", mem_req, 0);
    check("sw_fault_memwrite", MemWrite, 0);
    check("sw_stall", stall_cycles, 16);
    check("sw_retired", retired, 1);
    mem_ready = 1'b1; tick();
    check("fault_sticky", fault, 1);
    rst = 1'b1; #1;
    check("rst_fault_low", fault, 0);
    tick();
    rst = 1'b0;

    // HALT
    OpCode = 6'h3F; #1;
    check("halt_issue_pc_en", pc_en, 0);
    check("halt_issue_regwrite", RegWrite, 0);
    tick();
    check("halt_halted", halted, 1);
    check("halt_fault", fault, 0);
    check("halt_retired", retired, 1);
    OpCode = 6'h08; #1;
    check("halt_hold_pc_en", pc_en, 0);
    check("halt_hold_regwrite", RegWrite, 0);
    tick();
    check("halt_no_retire", retired, 1);
    check("halt_stays", halted, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
